// File: rtl/synch_fifo_pkg.sv
// synch_fifo_pkg: shared defaults, pointer-width helper and error-flag struct for synch_fifo.
package synch_fifo_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 8;

    typedef struct packed {
        logic ovf;
        logic udf;
    } synch_fifo_err_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/synch_fifo_if.sv
// synch_fifo_if: write/read handshake bundle for synch_fifo.
// ovf/udf exist only when SYNCH_FIFO_ERR_EN is defined.
interface synch_fifo_if
    import synch_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int AW = ptr_w(DEPTH);

    logic [WIDTH-1:0] wdata;
    logic             wen;
    logic             wrdy;
    logic [WIDTH-1:0] rdata;
    logic             ren;
    logic             rrdy;
    logic [AW-1:0]    level;
    logic             almost_full;
    logic             almost_empty;
`ifdef SYNCH_FIFO_ERR_EN
    logic             ovf;
    logic             udf;
`endif

    modport master (
        output wdata, wen, ren,
        input  wrdy, rdata, rrdy, level, almost_full, almost_empty
`ifdef SYNCH_FIFO_ERR_EN
        , input ovf, udf
`endif
    );

    modport slave (
        input  wdata, wen, ren,
        output wrdy, rdata, rrdy, level, almost_full, almost_empty
`ifdef SYNCH_FIFO_ERR_EN
        , output ovf, udf
`endif
    );

endinterface

// File: rtl/synch_fifo_ram.sv
// synch_fifo_ram: storage array with one synchronous write port and one asynchronous read port.
module synch_fifo_ram
    import synch_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/synch_fifo.sv
// synch_fifo: parametrised single-clock first-word-fall-through FIFO with flush, level and almost flags.
// Define SYNCH_FIFO_ERR_EN to add sticky overflow/underflow flags.
module synch_fifo
    import synch_fifo_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AFULL_LVL  = 6,
    parameter int AEMPTY_LVL = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    synch_fifo_if.slave  bus
);

    localparam int AW = ptr_w(DEPTH);
    localparam int IW = AW - 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("synch_fifo: DEPTH must be a power of two >= 2");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH || AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_lvl
        $error("synch_fifo: almost-full/almost-empty level out of range");
    end

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level;
    logic          full, empty, wr_acc, rd_acc;

    // Full when the wrap bits differ but the index bits match.
    assign empty  = wptr_q == rptr_q;
    assign full   = (wptr_q[AW-1] != rptr_q[AW-1]) && (wptr_q[IW-1:0] == rptr_q[IW-1:0]);
    assign wr_acc = bus.wen && !full;
    assign rd_acc = bus.ren && !empty;
    assign level  = wptr_q - rptr_q;

    always_comb begin
        wptr_d = clr_i ? '0 : wptr_q + AW'(wr_acc);
        rptr_d = clr_i ? '0 : rptr_q + AW'(rd_acc);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    synch_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_acc && !clr_i),
        .waddr_i (wptr_q[IW-1:0]),
        .wdata_i (bus.wdata),
        .raddr_i (rptr_q[IW-1:0]),
        .rdata_o (bus.rdata)
    );

    assign bus.wrdy         = !full;
    assign bus.rrdy         = !empty;
    assign bus.level        = level;
    assign bus.almost_full  = level >= AW'(AFULL_LVL);
    assign bus.almost_empty = level <= AW'(AEMPTY_LVL);

`ifdef SYNCH_FIFO_ERR_EN
    synch_fifo_err_t err_q, err_d;

    // A flush clears the flags and masks any rejected request in the same cycle.
    always_comb begin
        err_d     = err_q;
        err_d.ovf = !clr_i && (err_q.ovf || (bus.wen && full));
        err_d.udf = !clr_i && (err_q.udf || (bus.ren && empty));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) err_q <= '0;
        else          err_q <= err_d;
    end

    assign bus.ovf = err_q.ovf;
    assign bus.udf = err_q.udf;
`endif

endmodule
